// File: rtl/bird_datapath.sv
// Bird datapath: holds the bird position, steps it on move/fall/escape states and
// rasterises clear/draw bursts to the VGA write port. Optional macro: BIRD_SPRITE_EN.
module bird_datapath #(
    parameter int         BIRD_W      = 8,
    parameter int         BIRD_H      = 8,
    parameter int         X_START     = 76,
    parameter int         Y_START     = 90,
    parameter int         Y_GROUND    = 96,
    parameter int         MOVE_STEP   = 2,
    parameter int         FALL_STEP   = 4,
    parameter logic [2:0] BIRD_COLOUR = 3'b110,
    parameter logic [2:0] BG_COLOUR   = 3'b011
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] state,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done_drawing,
    output logic       flying,
    output logic [7:0] bird_x,
    output logic [6:0] bird_y
);

    typedef enum logic [3:0] {
        S_HOLD       = 4'd0,
        S_CLEAR      = 4'd1,
        S_UP_LEFT    = 4'd2,
        S_UP_RIGHT   = 4'd3,
        S_PREHOLD    = 4'd4,
        S_DRAW       = 4'd5,
        S_DOWN_RIGHT = 4'd6,
        S_DOWN_LEFT  = 4'd7,
        S_SHOT       = 4'd8,
        S_ESCAPE     = 4'd9,
        S_RESET      = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_FALL = 2'd1,
        MODE_RISE = 2'd2
    } mode_e;

    localparam logic signed [8:0] X_MAX    = 9'(160 - BIRD_W);
    localparam logic signed [8:0] Y_MAX    = 9'(Y_GROUND - BIRD_H);
    localparam logic signed [8:0] Y_GND    = 9'(Y_GROUND);
    localparam logic signed [8:0] M_STEP   = 9'(MOVE_STEP);
    localparam logic signed [8:0] F_STEP   = 9'(FALL_STEP);
    localparam logic [4:0]        COL_LAST = 5'(BIRD_W - 1);
    localparam logic [4:0]        ROW_LAST = 5'(BIRD_H - 1);
    localparam logic [7:0]        X_INIT   = 8'(X_START);
    localparam logic [6:0]        Y_INIT   = 7'(Y_START);

    logic [3:0]  prev_state_q;
    logic [7:0]  bird_x_q, bird_x_d;
    logic [6:0]  bird_y_q, bird_y_d;
    logic        flying_q, flying_d;
    mode_e       mode_q, mode_d;
    logic [4:0]  col_q, row_q;
    logic        active_q;
    logic [7:0]  base_x_q;
    logic [6:0]  base_y_q;
    logic [7:0]  x_out_q;
    logic [6:0]  y_out_q;
    logic [2:0]  colour_q;
    logic        plot_q;
    logic        done_q;

    logic              entry;
    logic              in_burst;
    logic              last_pix;
    logic              do_move;
    logic signed [8:0] dx, dy;
    logic signed [8:0] ext_x, ext_y;
    logic signed [8:0] sum_x, sum_y;
    logic [2:0]        pix_colour;

    assign entry    = (state != prev_state_q);
    assign in_burst = (state == S_CLEAR) || (state == S_DRAW);
    assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign ext_x    = $signed({1'b0, bird_x_q});
    assign ext_y    = $signed({2'b00, bird_y_q});

`ifdef BIRD_SPRITE_EN
    // Bit index is row*8+col; row 0 is the least significant byte.
    localparam logic [63:0] SPRITE = 64'h0024_3C7E_FFDB_7E3C;

    if (BIRD_W != 8 || BIRD_H != 8) begin : g_bad_sprite_size
        $error("BIRD_SPRITE_EN requires BIRD_W == 8 and BIRD_H == 8");
    end

    assign pix_colour = (state == S_CLEAR) ? BG_COLOUR :
                        (SPRITE[{row_q[2:0], col_q[2:0]}] ? BIRD_COLOUR : BG_COLOUR);
`else
    assign pix_colour = (state == S_CLEAR) ? BG_COLOUR : BIRD_COLOUR;
`endif

    // Position / flight update: every action happens only on the entry cycle of a state.
    always_comb begin
        bird_x_d = bird_x_q;
        bird_y_d = bird_y_q;
        flying_d = flying_q;
        mode_d   = mode_q;
        do_move  = 1'b0;
        dx       = '0;
        dy       = '0;
        sum_x    = '0;
        sum_y    = '0;
        if (entry) begin
            case (state)
                S_UP_RIGHT: begin
                    do_move = 1'b1;
                    dx      = M_STEP;
                    dy      = -M_STEP;
                end
                S_UP_LEFT: begin
                    do_move = 1'b1;
                    dx      = -M_STEP;
                    dy      = -M_STEP;
                end
                S_DOWN_RIGHT: begin
                    do_move = 1'b1;
                    dx      = M_STEP;
                    dy      = M_STEP;
                end
                S_DOWN_LEFT: begin
                    do_move = 1'b1;
                    dx      = -M_STEP;
                    dy      = M_STEP;
                end
                S_SHOT: begin
                    flying_d = 1'b1;
                    mode_d   = MODE_FALL;
                end
                S_ESCAPE: begin
                    flying_d = 1'b1;
                    mode_d   = MODE_RISE;
                end
                S_RESET: begin
                    bird_x_d = X_INIT;
                    bird_y_d = Y_INIT;
                    flying_d = 1'b0;
                    mode_d   = MODE_NONE;
                end
                S_DRAW: begin
                    if (flying_q && mode_q == MODE_FALL) begin
                        sum_y = ext_y + F_STEP;
                        if (sum_y >= Y_GND) begin
                            bird_y_d = Y_GND[6:0];
                            flying_d = 1'b0;
                        end else begin
                            bird_y_d = sum_y[6:0];
                        end
                    end else if (flying_q && mode_q == MODE_RISE) begin
                        if (ext_y < F_STEP) begin
                            bird_y_d = '0;
                            flying_d = 1'b0;
                        end else begin
                            sum_y    = ext_y - F_STEP;
                            bird_y_d = sum_y[6:0];
                        end
                    end
                end
                default: ;
            endcase

            // Saturate each axis independently at its screen bound.
            if (do_move) begin
                sum_x = ext_x + dx;
                sum_y = ext_y + dy;
                if (sum_x < 0) begin
                    bird_x_d = '0;
                end else if (sum_x > X_MAX) begin
                    bird_x_d = X_MAX[7:0];
                end else begin
                    bird_x_d = sum_x[7:0];
                end
                if (sum_y < 0) begin
                    bird_y_d = '0;
                end else if (sum_y > Y_MAX) begin
                    bird_y_d = Y_MAX[6:0];
                end else begin
                    bird_y_d = sum_y[6:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_state_q <= S_PREHOLD;
            bird_x_q     <= X_INIT;
            bird_y_q     <= Y_INIT;
            flying_q     <= 1'b0;
            mode_q       <= MODE_NONE;
            col_q        <= '0;
            row_q        <= '0;
            active_q     <= 1'b0;
            base_x_q     <= '0;
            base_y_q     <= '0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            prev_state_q <= state;
            bird_x_q     <= bird_x_d;
            bird_y_q     <= bird_y_d;
            flying_q     <= flying_d;
            mode_q       <= mode_d;
            plot_q       <= 1'b0;
            if (entry) begin
                // Latch the burst origin after any flight step so DRAW uses the new spot.
                col_q    <= '0;
                row_q    <= '0;
                done_q   <= 1'b0;
                active_q <= in_burst;
                if (in_burst) begin
                    base_x_q <= bird_x_d;
                    base_y_q <= bird_y_d;
                end
            end else if (in_burst) begin
                if (active_q) begin
                    x_out_q  <= base_x_q + 8'(col_q);
                    y_out_q  <= base_y_q + 7'(row_q);
                    colour_q <= pix_colour;
                    plot_q   <= 1'b1;
                    if (last_pix) begin
                        active_q <= 1'b0;
                    end else if (col_q == COL_LAST) begin
                        col_q <= '0;
                        row_q <= row_q + 5'd1;
                    end else begin
                        col_q <= col_q + 5'd1;
                    end
                end else begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign x_out        = x_out_q;
    assign y_out        = y_out_q;
    assign colour       = colour_q;
    assign plot         = plot_q;
    assign done_drawing = done_q;
    assign flying       = flying_q || (state == S_SHOT) || (state == S_ESCAPE);
    assign bird_x       = bird_x_q;
    assign bird_y       = bird_y_q;

endmodule

// File: tb/tb_bird_datapath.sv
// Directed self-checking bench for bird_datapath: bursts, moves, clamps, fall/escape, reset.
module tb_bird_datapath;

    localparam logic [3:0] ST_HOLD       = 4'd0;
    localparam logic [3:0] ST_CLEAR      = 4'd1;
    localparam logic [3:0] ST_UP_LEFT    = 4'd2;
    localparam logic [3:0] ST_UP_RIGHT   = 4'd3;
    localparam logic [3:0] ST_PREHOLD    = 4'd4;
    localparam logic [3:0] ST_DRAW       = 4'd5;
    localparam logic [3:0] ST_DOWN_RIGHT = 4'd6;
    localparam logic [3:0] ST_SHOT       = 4'd8;
    localparam logic [3:0] ST_ESCAPE     = 4'd9;
    localparam logic [3:0] ST_RESET      = 4'd10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] state;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot;
    logic       done_drawing;
    logic       flying;
    logic [7:0] bird_x;
    logic [6:0] bird_y;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bird_datapath dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .state        (state),
        .x_out        (x_out),
        .y_out        (y_out),
        .colour       (colour),
        .plot         (plot),
        .done_drawing (done_drawing),
        .flying       (flying),
        .bird_x       (bird_x),
        .bird_y       (bird_y)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic go(input logic [3:0] s, input int n);
        state = s;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check({tag, "_bird_x"}, bird_x, ex);
        check({tag, "_bird_y"}, bird_y, ey);
        $display("pos %s: bird=(%0d,%0d) flying=%0d", tag, bird_x, bird_y, flying);
    endtask

    // Drive a CLEAR/DRAW burst to completion and check every plotted pixel.
    task automatic burst(input logic [3:0] s, input int bx, input int by,
                         input logic [2:0] c, input string tag);
        int n        = 0;
        int cyc      = 0;
        int last_cyc = -100;
        bit seen     = 1'b0;
        state = s;
        while (cyc < 200 && !seen) begin
            @(posedge clk);
            #1;
            cyc++;
            if (plot) begin
                check({tag, "_x"}, x_out, bx + (n % 8));
                check({tag, "_y"}, y_out, by + (n / 8));
                check({tag, "_colour"}, colour, c);
                n++;
                last_cyc = cyc;
            end
            if (done_drawing) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_plot_count"}, n, 64);
        check({tag, "_done_latency"}, cyc - last_cyc, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_done_hold"}, done_drawing, 1);
        check({tag, "_plot_idle"}, plot, 0);
        $display("burst %s: %0d plots from (%0d,%0d)", tag, n, bx, by);
    endtask

    initial begin
        int n;
        int cyc;

        // Reset state
        reset_n = 1'b0;
        state   = ST_PREHOLD;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bird_x", bird_x, 76);
        check("rst_bird_y", bird_y, 90);
        check("rst_plot", plot, 0);
        check("rst_done", done_drawing, 0);
        check("rst_flying", flying, 0);
        check("rst_x_out", x_out, 0);
        check("rst_y_out", y_out, 0);
        check("rst_colour", colour, 0);
        reset_n = 1'b1;
        go(ST_PREHOLD, 2);
        check("prehold_plot", plot, 0);

        // Draw from reset position, then clear / move / draw
        burst(ST_DRAW, 76, 90, 3'b110, "draw0");
        burst(ST_CLEAR, 76, 90, 3'b011, "clear0");
        go(ST_UP_RIGHT, 1);
        check_pos("up_right", 78, 88);
        check("move_plot", plot, 0);
        burst(ST_DRAW, 78, 88, 3'b110, "draw1");

        // Climb to y=80, then shot and fall
        go(ST_UP_LEFT, 1);
        go(ST_UP_RIGHT, 1);
        go(ST_UP_LEFT, 1);
        go(ST_UP_RIGHT, 1);
        check_pos("pre_shot", 78, 80);
        state = ST_SHOT;
        #1;
        check("shot_flying_same_cycle", flying, 1);
        go(ST_SHOT, 1);
        go(ST_DRAW, 1);
        check_pos("fall1", 78, 84);
        go(ST_HOLD, 1);
        check("fall1_flying", flying, 1);
        check("hold_plot", plot, 0);
        go(ST_DRAW, 1);
        check_pos("fall2", 78, 88);
        go(ST_HOLD, 1);
        go(ST_DRAW, 1);
        check_pos("fall3", 78, 92);
        go(ST_HOLD, 1);
        go(ST_DRAW, 1);
        check_pos("fall4", 78, 96);
        check("fall_landed_flying", flying, 0);
        go(ST_HOLD, 1);
        go(ST_RESET, 1);
        check_pos("reset_state", 76, 90);
        check("reset_state_flying", flying, 0);

        // Escape: rise 4 per DRAW entry down to y=6, then 2, then park at 0
        go(ST_ESCAPE, 1);
        for (int i = 0; i < 21; i++) begin
            go(ST_DRAW, 1);
            go(ST_HOLD, 1);
        end
        check_pos("escape_y6", 76, 6);
        check("escape_y6_flying", flying, 1);
        go(ST_ESCAPE, 1);
        go(ST_DRAW, 1);
        check_pos("escape_y2", 76, 2);
        check("escape_y2_flying", flying, 1);
        go(ST_HOLD, 1);
        go(ST_DRAW, 1);
        check_pos("escape_y0", 76, 0);
        check("escape_y0_flying", flying, 0);
        go(ST_HOLD, 1);

        // Clamping at both bounds
        go(ST_RESET, 1);
        go(ST_UP_LEFT, 1);
        go(ST_HOLD, 1);
        go(ST_UP_LEFT, 1);
        check_pos("pre_clamp", 72, 86);
        go(ST_DOWN_RIGHT, 1);
        check_pos("down_to_88", 74, 88);
        go(ST_HOLD, 1);
        go(ST_DOWN_RIGHT, 1);
        check_pos("y_sat_high", 76, 88);
        for (int i = 0; i < 45; i++) begin
            go(ST_HOLD, 1);
            go(ST_DOWN_RIGHT, 1);
        end
        check_pos("x_sat_high", 152, 88);
        for (int i = 0; i < 90; i++) begin
            go(ST_HOLD, 1);
            go(ST_UP_LEFT, 1);
        end
        check_pos("sat_low", 0, 0);

        // Reset asserted mid-burst
        go(ST_HOLD, 1);
        state = ST_DRAW;
        n     = 0;
        cyc   = 0;
        while (n < 20 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (plot) n++;
        end
        check("midrst_reached_20", n, 20);
        reset_n = 1'b0;
        #1;
        check("midrst_plot", plot, 0);
        check("midrst_x_out", x_out, 0);
        check("midrst_y_out", y_out, 0);
        check("midrst_colour", colour, 0);
        check("midrst_done", done_drawing, 0);
        check("midrst_flying", flying, 0);
        check_pos("midrst", 76, 90);
        state = ST_PREHOLD;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        go(ST_PREHOLD, 1);
        burst(ST_DRAW, 76, 90, 3'b110, "redraw");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
